// File: rtl/regfile_mp_pkg.sv
//==============================================================================
// Module      : regfile_mp_pkg
// Description : Shared types and helpers for the multi-port register file.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package regfile_mp_pkg;

    localparam int c_def_xlen  = 32;
    localparam int c_def_nregs = 32;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // Elaboration-time ceil(log2(n)); n is expected to be a power of two >= 2.
    function automatic int rf_clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : regfile_mp_pkg

`default_nettype wire

// File: rtl/regfile_mp_clear_fsm.sv
//==============================================================================
// Module      : regfile_mp_clear_fsm
// Description : Sequential clear engine; walks every entry once after reset or
//               on request, holding busy for exactly NREGS cycles.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_mp_clear_fsm
    import regfile_mp_pkg::*;
#(
    parameter  int NREGS = c_def_nregs,
    localparam int AW    = rf_clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] c_last_idx = AW'(NREGS - 1);

    rf_state_e     r_state;
    rf_state_e     w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            RF_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = RF_CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            RF_CLEAR: begin
                w_idx_nxt = r_idx + AW'(1);
                if (r_idx == c_last_idx) begin
                    w_state_nxt = RF_IDLE;
                end
            end
            default: begin
                w_state_nxt = RF_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // The array is left untouched while rst is held; the sweep starts on the first free edge.
    assign busy    = (r_state == RF_CLEAR);
    assign clr_we  = busy & ~rst;
    assign clr_idx = r_idx;

endmodule : regfile_mp_clear_fsm

`default_nettype wire

// File: rtl/regfile_mp.sv
//==============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port integer register file with optional
//               hardwired-zero x0 and a sequential clear engine.
//               Build option: REGFILE_BYPASS_EN enables write-to-read forwarding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int XLEN     = c_def_xlen,
    parameter  int NREGS    = c_def_nregs,
    parameter  int NRD      = 2,
    parameter  int NWR      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = rf_clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    output logic                busy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata
);

    localparam bit c_zero_en = (ZERO_REG != 0);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_clr_we;
    logic [AW-1:0]   w_clr_idx;
    logic            w_wr_ok;
    logic [NWR-1:0]  w_wr_qual;

    regfile_mp_clear_fsm #(
        .NREGS   (NREGS)
    ) u_clear_fsm (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (w_clr_we),
        .clr_idx (w_clr_idx)
    );

    // Any edge that starts a clear discards the user writes presented with it.
    assign w_wr_ok = ~busy & ~rst & ~clr_req;

    for (genvar k = 0; k < NWR; k++) begin : g_wr_qual
        assign w_wr_qual[k] = we[k] & w_wr_ok &
                              ~(c_zero_en && (waddr[k*AW +: AW] == '0));
    end

    // Ascending port order: the highest-index port lands last and wins a conflict.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_regs[w_clr_idx] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (w_wr_qual[k]) begin
                    r_regs[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd_port
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd_val;

        assign w_ra = raddr[j*AW +: AW];

        always_comb begin
            w_rd_val = r_regs[w_ra];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (w_wr_qual[k] && (waddr[k*AW +: AW] == w_ra)) begin
                    w_rd_val = wdata[k*XLEN +: XLEN];
                end
            end
`endif
            if (busy || (c_zero_en && (w_ra == '0))) begin
                w_rd_val = '0;
            end
        end

        assign rdata[j*XLEN +: XLEN] = w_rd_val;
    end

endmodule : regfile_mp

`default_nettype wire

// File: tb/tb_regfile_mp.sv
//==============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp against an array-level model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                clr_req;
    logic                busy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr    (raddr),
        .rdata    (rdata)
    );

    // Reference model: register contents plus the number of busy cycles still owed.
    logic [XLEN-1:0] mregs [NREGS];
    int              mbusy;
    bit              mknown;
    int              n_chk;
    int              n_err;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] mread(input int a);
        if (mbusy > 0 || a == 0) return '0;
        return mregs[a];
    endfunction

    task automatic set_w(input int k, input logic en, input int a, input logic [XLEN-1:0] d);
        we[k]                 = en;
        waddr[k*AW +: AW]     = AW'(a);
        wdata[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_r(input int j, input int a);
        raddr[j*AW +: AW] = AW'(a);
    endtask

    task automatic model_wipe();
        mbusy = NREGS;
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
    endtask

    // Check outputs mid-cycle, advance the model by the edge rules, then cross the edge.
    task automatic cycle();
        int a;
        @(negedge clk);
        if (mknown) begin
            chk("busy", XLEN'(busy), XLEN'(mbusy > 0));
            for (int j = 0; j < NRD; j++) begin
                a = int'(raddr[j*AW +: AW]);
                chk($sformatf("rd%0d_a%0d", j, a), rdata[j*XLEN +: XLEN], mread(a));
            end
        end
        if (rst) begin
            model_wipe();
            mknown = 1'b1;
        end else if (mbusy > 0) begin
            mbusy--;
        end else if (clr_req) begin
            model_wipe();
        end else begin
            for (int k = 0; k < NWR; k++) begin
                a = int'(waddr[k*AW +: AW]);
                if (we[k] && a != 0) mregs[a] = wdata[k*XLEN +: XLEN];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs(input bit allow_we);
        for (int k = 0; k < NWR; k++)
            set_w(k, allow_we ? 1'($urandom_range(0, 1)) : 1'b0,
                  int'($urandom_range(0, NREGS - 1)), $urandom);
        for (int j = 0; j < NRD; j++) set_r(j, int'($urandom_range(0, NREGS - 1)));
    endtask

    initial begin
        int nb;
        n_chk = 0; n_err = 0; mbusy = 0; mknown = 1'b0;
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        rst = 1'b1; clr_req = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0;

        // Reset: busy for NREGS cycles, then every entry reads zero
        cycle();
        rst = 1'b0;
        chk("t1_busy_after_rst", XLEN'(busy), 32'd1);
        repeat (NREGS) cycle();
        chk("t1_busy_done", XLEN'(busy), 32'd0);
        for (int a = 0; a < NREGS; a++) begin
            set_r(0, a); set_r(1, NREGS - 1 - a);
            cycle();
        end

        // Write then read the following cycle
        set_w(0, 1'b1, 5, 32'hDEADBEEF);
        cycle();
        we = '0; set_r(0, 5); set_r(1, 0);
        #1;
        chk("t2_rd5", rdata[0 +: XLEN], 32'hDEADBEEF);
        chk("t2_rd0", rdata[XLEN +: XLEN], 32'h0);
        cycle();

        // Same-address conflict: upper port wins; x0 ignores writes
        set_w(0, 1'b1, 7, 32'h11); set_w(1, 1'b1, 7, 32'h22);
        cycle();
        we = '0; set_r(0, 7);
        #1;
        chk("t3_conflict", rdata[0 +: XLEN], 32'h22);
        set_w(1, 1'b1, 0, 32'h33);
        cycle();
        we = '0; set_r(0, 0);
        #1;
        chk("t3_x0", rdata[0 +: XLEN], 32'h0);
        cycle();

        // Clear on request with writes attempted while busy
        for (int a = 1; a < NREGS; a++) begin
            set_w(0, 1'b1, a, XLEN'(a)); set_w(1, 1'b0, 0, '0);
            cycle();
        end
        we = '0; set_r(0, 17); set_r(1, 31);
        #1;
        chk("t4_fill17", rdata[0 +: XLEN], 32'd17);
        chk("t4_fill31", rdata[XLEN +: XLEN], 32'd31);
        clr_req = 1'b1;
        set_w(0, 1'b1, 9, 32'hBAD0BAD0);
        cycle();
        clr_req = 1'b0;
        repeat (NREGS) begin
            rand_inputs(1'b1);
            we = '1;
            cycle();
        end
        we = '0;
        for (int a = 0; a < NREGS; a++) begin
            set_r(0, a); set_r(1, (a * 7) % NREGS);
            #1;
            chk($sformatf("t4_zero_%0d", a), rdata[0 +: XLEN], 32'h0);
            cycle();
        end

        // Reset in the middle of a clear restarts the full sweep
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        repeat (10) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        nb = int'(busy);
        repeat (NREGS + 8) begin
            cycle();
            nb += int'(busy);
        end
        chk("t5_busy_len", XLEN'(nb), XLEN'(NREGS));

        // Same-cycle write and read of one register
        set_w(0, 1'b1, 3, 32'h1234);
        cycle();
        set_w(0, 1'b1, 3, 32'hA5A5); set_r(0, 3);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("t6_same_cycle", rdata[0 +: XLEN], 32'hA5A5);
`else
        chk("t6_same_cycle", rdata[0 +: XLEN], 32'h1234);
`endif
        cycle();
        we = '0;
        #1;
        chk("t6_next_cycle", rdata[0 +: XLEN], 32'hA5A5);

        // Randomised traffic with occasional clear requests and resets
        repeat (600) begin
            rand_inputs(1'b1);
            clr_req = ($urandom_range(0, 59) == 0);
            rst     = ($urandom_range(0, 249) == 0);
            cycle();
        end
        rst = 1'b0; clr_req = 1'b0; we = '0;
        repeat (NREGS + 2) begin
            rand_inputs(1'b0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_regfile_mp

`default_nettype wire
